clkdiv_prog: RTL and testbench

CLKDIV_PROG -- requirements
Module: clkdiv_prog

---
 rtl/clkdiv_prog_if.sv | 51 +++++
 rtl/clkdiv_prog.sv | 134 +++++++++++++
 tb/tb_clkdiv_prog.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clkdiv_prog_if.sv
// clkdiv_prog_if -- control and output bundle of the programmable clock divider.
//
// Signals:
//   en       : count enable
//   mode     : 0 = square wave on clk_div, 1 = one-cycle pulse on clk_div
//   div_in   : requested divisor (clk cycles per terminal count), WIDTH bits
//   div_load : one-cycle strobe that captures div_in as the pending divisor
//   div_busy : a captured divisor is pending and not yet active
//   clk_div  : divided clock output (registered)
//   tick     : one-cycle pulse after every terminal count (registered)
//
// Handshake: div_load is a fire-and-forget strobe that is accepted on every
// rising clk edge where it is 1; there is no back-pressure. div_busy is
// status only: it rises on the edge that captures a divisor and falls on the
// edge that makes that divisor active. A load while div_busy=1 replaces the
// pending value (last load wins).
//
// Modports:
//   master : the controller side (drives en/mode/div_in/div_load)
//   slave  : the divider side (drives div_busy/clk_div/tick)
interface clkdiv_prog_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic             mode;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             div_busy;
    logic             clk_div;
    logic             tick;

    modport master (
        output en,
        output mode,
        output div_in,
        output div_load,
        input  div_busy,
        input  clk_div,
        input  tick
    );

    modport slave (
        input  en,
        input  mode,
        input  div_in,
        input  div_load,
        output div_busy,
        output clk_div,
        output tick
    );
endinterface

// File: rtl/clkdiv_prog.sv
// clkdiv_prog -- programmable clock divider with glitch-free divisor reload.
//
// A WIDTH-bit counter runs from 0 to div_q-1; the edge where it wraps is the
// terminal count (TC). At each TC, clk_div toggles (mode 0, period 2*div_q)
// or pulses high for one cycle (mode 1), and tick pulses for one cycle.
// New divisors are captured into a pending register and only swapped in at
// a TC (or immediately while counting is disabled), so a period in progress
// is never cut short or stretched.
//
// Ports:
//   clk : single clock, all state changes on its rising edge
//   rst : asynchronous active-low reset
//   bus : clkdiv_prog_if slave modport (en, mode, div_in, div_load in;
//         div_busy, clk_div, tick out)
module clkdiv_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 50000
) (
    input  logic         clk,
    input  logic         rst,
    clkdiv_prog_if.slave bus
);

    localparam longint MAX_DIV = (longint'(1) << WIDTH) - 1;

    if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
        $fatal(1, "clkdiv_prog: WIDTH must be in 1..31");
    end

    if (DEFAULT_DIV < 1 || longint'(DEFAULT_DIV) > MAX_DIV) begin : g_bad_default
        $fatal(1, "clkdiv_prog: DEFAULT_DIV must be in 1..2^WIDTH-1");
    end

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    // Registered state
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_p;
    logic [WIDTH-1:0] cnt;
    logic             clk_div_r;
    logic             tick_r;
    logic             busy_r;

    // Next-state values
    logic [WIDTH-1:0] div_q_nxt;
    logic [WIDTH-1:0] div_p_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             clk_div_nxt;
    logic             tick_nxt;
    logic             busy_nxt;

    logic [WIDTH-1:0] load_div;
    logic             tc;

    // A requested divisor of 0 is stored as 1, so div_q and div_p are never 0
    // and div_q-1 below cannot wrap.
    assign load_div = (bus.div_in == '0) ? ONE : bus.div_in;

    // ">=" rather than "==" so an out-of-range count recovers at once by
    // being treated as a terminal count.
    assign tc = (cnt >= (div_q - ONE));

    always_comb begin
        div_q_nxt   = div_q;
        div_p_nxt   = div_p;
        cnt_nxt     = cnt;
        clk_div_nxt = clk_div_r;
        tick_nxt    = 1'b0;
        busy_nxt    = busy_r;

        if (bus.en) begin
            tick_nxt = tc;
            cnt_nxt  = tc ? '0 : (cnt + ONE);

            if (bus.mode) begin
                clk_div_nxt = tc;
            end else if (tc) begin
                clk_div_nxt = ~clk_div_r;
            end

            // A divisor that was already pending takes effect at this TC.
            if (tc && busy_r) begin
                div_q_nxt = div_p;
                busy_nxt  = 1'b0;
            end

            // A load on the same edge queues behind it and waits for the
            // next TC.
            if (bus.div_load) begin
                div_p_nxt = load_div;
                busy_nxt  = 1'b1;
            end
        end else begin
            if (bus.mode) begin
                clk_div_nxt = 1'b0;
            end

            if (bus.div_load) begin
                div_p_nxt = load_div;
                busy_nxt  = 1'b1;
            end else if (busy_r) begin
                // Counting is paused, so no period is running: apply now and
                // restart the count from zero.
                div_q_nxt = div_p;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q     <= DEF_DIV;
            div_p     <= DEF_DIV;
            cnt       <= '0;
            clk_div_r <= 1'b0;
            tick_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            div_q     <= div_q_nxt;
            div_p     <= div_p_nxt;
            cnt       <= cnt_nxt;
            clk_div_r <= clk_div_nxt;
            tick_r    <= tick_nxt;
            busy_r    <= busy_nxt;
        end
    end

    assign bus.clk_div  = clk_div_r;
    assign bus.tick     = tick_r;
    assign bus.div_busy = busy_r;

endmodule

// File: tb/tb_clkdiv_prog.sv
// tb_clkdiv_prog -- self-checking bench for clkdiv_prog (WIDTH=8, DEFAULT_DIV=4).
// Directed scenario tasks followed by a randomized run compared cycle by cycle
// against a countdown-based reference model through an expected queue.
module tb_clkdiv_prog;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic rst     = 1'b0;
    logic clk_run = 1'b1;

    initial begin
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    clkdiv_prog_if #(.WIDTH(W)) bus ();

    clkdiv_prog #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        bus.en       = 1'b0;
        bus.mode     = 1'b0;
        bus.div_in   = '0;
        bus.div_load = 1'b0;
    endtask

    task automatic drive(input logic en, input logic mode, input logic load, input logic [W-1:0] din);
        bus.en       = en;
        bus.mode     = mode;
        bus.div_load = load;
        bus.div_in   = din;
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after an edge with rst released; the next
    // rising edge is edge 1 after reset.
    task automatic do_reset();
        rst = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- reference model + scoreboard ----------------
    // Tracks "edges left until the next terminal count" rather than a count.
    int   m_div;
    int   m_pend;
    int   m_left;
    bit   m_busy;
    bit   m_out;
    bit   m_tick;
    logic [2:0] exp_q[$];

    task automatic model_reset();
        m_div  = 4;
        m_pend = 4;
        m_left = 4;
        m_busy = 0;
        m_out  = 0;
        m_tick = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input bit en, input bit mode, input bit load, input int din);
        int nd;
        bit tc;
        nd = (din == 0) ? 1 : din;
        if (en) begin
            tc = (m_left <= 1);
            if (tc && m_busy) begin
                m_div  = m_pend;
                m_busy = 0;
            end
            if (load) begin
                m_pend = nd;
                m_busy = 1;
            end
            m_left = tc ? m_div : m_left - 1;
            m_tick = tc;
            if (mode) m_out = tc;
            else if (tc) m_out = !m_out;
        end else begin
            m_tick = 0;
            if (mode) m_out = 0;
            if (load) begin
                m_pend = nd;
                m_busy = 1;
            end else if (m_busy) begin
                m_div  = m_pend;
                m_busy = 0;
                m_left = m_div;
            end
        end
        exp_q.push_back({m_busy, m_out, m_tick});
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        set_idle();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b required 0", bus.tick); end
        n_cmp++;
        if (bus.clk_div !== 1'b0) begin n_err++; $display("FAIL reset_clk_div: got %b required 0", bus.clk_div); end
        n_cmp++;
        if (bus.div_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", bus.div_busy); end
        bus.en = 1'b1;
        repeat (5) step();
        n_cmp++;
        if ({bus.div_busy, bus.clk_div, bus.tick} !== 3'b000)
            begin n_err++; $display("FAIL reset_held: got %b required 000", {bus.div_busy, bus.clk_div, bus.tick}); end
        set_idle();
    endtask

    task automatic test_basic();
        logic exp_clk;
        do_reset();
        drive(1, 0, 0, 0);
        for (int e = 1; e <= 16; e++) begin
            step();
            exp_clk = ((e / 4) % 2) == 1;
            n_cmp++;
            if (bus.tick !== (e % 4 == 0))
                begin n_err++; $display("FAIL basic_tick e=%0d: got %b required %b", e, bus.tick, (e % 4 == 0)); end
            n_cmp++;
            if (bus.clk_div !== exp_clk)
                begin n_err++; $display("FAIL basic_clk_div e=%0d: got %b required %b", e, bus.clk_div, exp_clk); end
        end
        set_idle();
    endtask

    task automatic test_reload();
        logic exp_clk;
        do_reset();
        drive(1, 0, 0, 0);
        step();                       // edge 1, cnt=1
        drive(1, 0, 1, 8'd2);
        step();                       // edge 2, load captured
        drive(1, 0, 0, 0);
        n_cmp++;
        if (bus.div_busy !== 1'b1) begin n_err++; $display("FAIL reload_busy_set: got %b required 1", bus.div_busy); end
        step();                       // edge 3
        n_cmp++;
        if (bus.div_busy !== 1'b1) begin n_err++; $display("FAIL reload_busy_hold: got %b required 1", bus.div_busy); end
        for (int e = 4; e <= 13; e++) begin
            step();
            exp_clk = (((e - 4) / 2) % 2) == 0;
            n_cmp++;
            if (bus.div_busy !== 1'b0)
                begin n_err++; $display("FAIL reload_busy_clear e=%0d: got %b required 0", e, bus.div_busy); end
            n_cmp++;
            if (bus.tick !== (e % 2 == 0))
                begin n_err++; $display("FAIL reload_tick e=%0d: got %b required %b", e, bus.tick, (e % 2 == 0)); end
            n_cmp++;
            if (bus.clk_div !== exp_clk)
                begin n_err++; $display("FAIL reload_clk_div e=%0d: got %b required %b", e, bus.clk_div, exp_clk); end
        end
        set_idle();
    endtask

    task automatic test_div_zero();
        do_reset();
        drive(1, 0, 1, 8'd0);
        step();                       // edge 1, load 0 (treated as 1)
        drive(1, 0, 0, 0);
        repeat (3) step();            // TC at edge 4 applies it
        for (int e = 5; e <= 14; e++) begin
            step();
            n_cmp++;
            if (bus.tick !== 1'b1)
                begin n_err++; $display("FAIL div0_tick e=%0d: got %b required 1", e, bus.tick); end
            n_cmp++;
            if (bus.clk_div !== (e % 2 == 0))
                begin n_err++; $display("FAIL div0_clk_div e=%0d: got %b required %b", e, bus.clk_div, (e % 2 == 0)); end
        end
        set_idle();
    endtask

    task automatic test_pulse();
        logic prev_clk;
        logic exp_hi;
        do_reset();
        drive(1, 1, 1, 8'd5);
        step();
        drive(1, 1, 0, 0);
        repeat (3) step();            // TC at edge 4 applies divisor 5
        prev_clk = bus.clk_div;
        for (int e = 5; e <= 34; e++) begin
            step();
            exp_hi = ((e - 4) % 5) == 0;
            n_cmp++;
            if (bus.clk_div !== exp_hi)
                begin n_err++; $display("FAIL pulse_clk_div e=%0d: got %b required %b", e, bus.clk_div, exp_hi); end
            n_cmp++;
            if (bus.tick !== exp_hi)
                begin n_err++; $display("FAIL pulse_tick e=%0d: got %b required %b", e, bus.tick, exp_hi); end
            n_cmp++;
            if ((prev_clk & bus.clk_div) !== 1'b0)
                begin n_err++; $display("FAIL pulse_width e=%0d: got two high cycles required one", e); end
            prev_clk = bus.clk_div;
        end
        set_idle();
    endtask

    task automatic test_en_off();
        do_reset();
        drive(1, 0, 0, 0);
        repeat (4) step();            // TC at edge 4, clk_div=1
        drive(0, 0, 1, 8'd6);
        step();                       // load while disabled
        n_cmp++;
        if ({bus.div_busy, bus.clk_div, bus.tick} !== 3'b110)
            begin n_err++; $display("FAIL enoff_load: got %b required 110", {bus.div_busy, bus.clk_div, bus.tick}); end
        drive(0, 0, 0, 0);
        step();                       // applied immediately, cnt cleared
        n_cmp++;
        if ({bus.div_busy, bus.clk_div, bus.tick} !== 3'b010)
            begin n_err++; $display("FAIL enoff_apply: got %b required 010", {bus.div_busy, bus.clk_div, bus.tick}); end
        drive(1, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            n_cmp++;
            if (bus.tick !== (k == 6))
                begin n_err++; $display("FAIL enoff_tick k=%0d: got %b required %b", k, bus.tick, (k == 6)); end
            n_cmp++;
            if (bus.clk_div !== (k != 6))
                begin n_err++; $display("FAIL enoff_clk_div k=%0d: got %b required %b", k, bus.clk_div, (k != 6)); end
        end
        set_idle();
    endtask

    task automatic test_back_to_back();
        // Two loads in a row: the second wins.
        do_reset();
        drive(1, 0, 1, 8'd2);
        step();
        drive(1, 0, 1, 8'd7);
        step();
        drive(1, 0, 0, 0);
        n_cmp++;
        if (bus.div_busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b required 1", bus.div_busy); end
        repeat (2) step();            // edge 4: TC, 7 becomes active
        n_cmp++;
        if (bus.div_busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_clear: got %b required 0", bus.div_busy); end
        for (int e = 5; e <= 11; e++) begin
            step();
            n_cmp++;
            if (bus.tick !== (e == 11))
                begin n_err++; $display("FAIL b2b_tick e=%0d: got %b required %b", e, bus.tick, (e == 11)); end
        end

        // Load landing exactly on a TC edge waits for the following TC.
        do_reset();
        drive(1, 0, 0, 0);
        repeat (3) step();
        drive(1, 0, 1, 8'd2);
        step();                       // edge 4: TC plus load
        drive(1, 0, 0, 0);
        n_cmp++;
        if ({bus.div_busy, bus.tick} !== 2'b11)
            begin n_err++; $display("FAIL tcload_edge: got %b required 11", {bus.div_busy, bus.tick}); end
        for (int e = 5; e <= 12; e++) begin
            step();
            n_cmp++;
            if (bus.tick !== (e == 8 || e == 10 || e == 12))
                begin n_err++; $display("FAIL tcload_tick e=%0d: got %b required %b", e, bus.tick, (e == 8 || e == 10 || e == 12)); end
            n_cmp++;
            if (bus.div_busy !== (e < 8))
                begin n_err++; $display("FAIL tcload_busy e=%0d: got %b required %b", e, bus.div_busy, (e < 8)); end
        end
        set_idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1, 0, 0, 0);
        repeat (4) step();            // clk_div high after edge 4
        drive(1, 0, 1, 8'd3);
        step();                       // edge 5: pending 3
        drive(1, 0, 0, 0);
        step();                       // edge 6: cnt=2
        clk_run = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.div_busy, bus.clk_div, bus.tick} !== 3'b000)
            begin n_err++; $display("FAIL async_reset: got %b required 000", {bus.div_busy, bus.clk_div, bus.tick}); end
        #2;
        rst = 1'b1;
        #2;
        clk_run = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            n_cmp++;
            if (bus.tick !== (e % 4 == 0))
                begin n_err++; $display("FAIL async_after_tick e=%0d: got %b required %b", e, bus.tick, (e % 4 == 0)); end
        end
        set_idle();
    endtask

    task automatic test_random();
        logic [2:0]   got;
        logic [2:0]   exp;
        logic         r_en;
        logic         r_mode;
        logic         r_load;
        logic [W-1:0] r_din;
        do_reset();
        model_reset();
        r_mode = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r_en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) r_mode = ~r_mode;
            r_load = ($urandom_range(0, 11) == 0);
            r_din  = W'($urandom_range(0, 9));
            if ($urandom_range(0, 49) == 0) r_din = W'($urandom_range(0, 40));
            drive(r_en, r_mode, r_load, r_din);
            model_edge(r_en, r_mode, r_load, int'(r_din));
            step();
            exp = exp_q.pop_front();
            got = {bus.div_busy, bus.clk_div, bus.tick};
            n_cmp++;
            if (got !== exp)
                begin n_err++; $display("FAIL random i=%0d {busy,clk_div,tick}: got %b required %b", i, got, exp); end
        end
        set_idle();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_reload();
        test_div_zero();
        test_pulse();
        test_en_off();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
